// File: rtl/alu_ctrl_exec.sv
// ALU control decoder plus executor: registered single-cycle ops and an iterative
// multu/divu unit with HI/LO registers. Define ALU_DIV_EN to include the divider.
module alu_ctrl_exec #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          SLT_SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             valid_in,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             valid_out,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_e;
`endif

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU, OP_ILL
  } op_e;

  state_e           state, state_nxt;
  logic             ready_nxt, valid_nxt, illegal_nxt, zero_nxt;
  logic [WIDTH-1:0] result_nxt, hi_nxt, lo_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [PW-1:0]    p, p_nxt;
  logic [WIDTH-1:0] opd, opd_nxt;

  op_e              op;
  logic             lt;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_p;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic [PW-1:0]    div_p;
`endif

  // Decode alu_op/funct into an operation
  always_comb begin
    op = OP_ILL;
    case (alu_op)
      3'b000: op = OP_ADD;
      3'b001: op = OP_SUB;
      3'b010: begin
        case (funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          6'b011001: op = OP_MULTU;
`ifdef ALU_DIV_EN
          6'b011011: op = OP_DIVU;
`endif
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // Single-cycle datapath; mfhi/mflo read the committed HI/LO
  always_comb begin
    if (SLT_SIGNED) lt = $signed(a_in) < $signed(b_in);
    else            lt = a_in < b_in;
    case (op)
      OP_ADD:  sc_res = a_in + b_in;
      OP_SUB:  sc_res = a_in - b_in;
      OP_AND:  sc_res = a_in & b_in;
      OP_OR:   sc_res = a_in | b_in;
      OP_SLT:  sc_res = WIDTH'(lt);
      OP_MFHI: sc_res = hi;
      OP_MFLO: sc_res = lo;
      default: sc_res = '0;
    endcase
  end

  // One shift-add step on {acc, multiplier}; p shifts right each cycle
  always_comb begin
    mul_sum = {1'b0, p[PW-1:WIDTH]} + (p[0] ? {1'b0, opd} : '0);
    mul_p   = {mul_sum, p[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  // One restoring-divide step on {remainder, dividend/quotient}
  always_comb begin
    div_sh   = p[PW-1:WIDTH-1];
    div_diff = {1'b0, div_sh} - {2'b0, opd};
    if (div_diff[WIDTH+1]) div_p = {div_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    else                   div_p = {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_nxt   = state;
    ready_nxt   = ready;
    valid_nxt   = 1'b0;
    illegal_nxt = illegal;
    result_nxt  = result;
    zero_nxt    = zero;
    hi_nxt      = hi;
    lo_nxt      = lo;
    cnt_nxt     = cnt;
    p_nxt       = p;
    opd_nxt     = opd;
    case (state)
      IDLE: begin
        if (valid_in && ready) begin
          cnt_nxt = '0;
          if (op == OP_MULTU) begin
            state_nxt = MUL;
            ready_nxt = 1'b0;
            opd_nxt   = a_in;
            p_nxt     = {{WIDTH{1'b0}}, b_in};
`ifdef ALU_DIV_EN
          end else if (op == OP_DIVU) begin
            state_nxt = DIV;
            ready_nxt = 1'b0;
            opd_nxt   = b_in;
            p_nxt     = {{WIDTH{1'b0}}, a_in};
`endif
          end else begin
            result_nxt  = sc_res;
            zero_nxt    = (sc_res == '0);
            illegal_nxt = (op == OP_ILL);
            valid_nxt   = 1'b1;
          end
        end
      end
      MUL: begin
        p_nxt   = mul_p;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          hi_nxt      = mul_p[PW-1:WIDTH];
          lo_nxt      = mul_p[WIDTH-1:0];
          result_nxt  = mul_p[WIDTH-1:0];
          zero_nxt    = (mul_p[WIDTH-1:0] == '0);
          illegal_nxt = 1'b0;
          valid_nxt   = 1'b1;
          ready_nxt   = 1'b1;
          state_nxt   = IDLE;
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        p_nxt   = div_p;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          hi_nxt      = div_p[PW-1:WIDTH];
          lo_nxt      = div_p[WIDTH-1:0];
          result_nxt  = div_p[WIDTH-1:0];
          zero_nxt    = (div_p[WIDTH-1:0] == '0);
          illegal_nxt = 1'b0;
          valid_nxt   = 1'b1;
          ready_nxt   = 1'b1;
          state_nxt   = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      p         <= '0;
      opd       <= '0;
    end else begin
      state     <= state_nxt;
      ready     <= ready_nxt;
      valid_out <= valid_nxt;
      illegal   <= illegal_nxt;
      result    <= result_nxt;
      zero      <= zero_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
      cnt       <= cnt_nxt;
      p         <= p_nxt;
      opd       <= opd_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Self-checking bench for alu_ctrl_exec: vector table for single-cycle ops, scoreboard
// for all results, and hand-written sequences for multiply/divide, stalls and reset abort.
module tb_alu_ctrl_exec;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a_in, b_in;
  logic         valid_in;
  logic         ready, zero, valid_out, illegal;
  logic [W-1:0] result, hi, lo;

  alu_ctrl_exec #(.WIDTH(W), .SLT_SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .a_in(a_in), .b_in(b_in),
    .valid_in(valid_in), .ready(ready), .result(result), .zero(zero),
    .valid_out(valid_out), .illegal(illegal), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         il;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         z;
    logic         il;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(string name, logic [W-1:0] res, logic il);
    exp_t e;
    e.name = name; e.res = res; e.z = (res == '0); e.il = il; e.hi = m_hi; e.lo = m_lo;
    return e;
  endfunction

  // Scoreboard: every valid_out must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid_out", W'(1), W'(0));
        end else begin
          e = q.pop_front();
          chk({e.name, ".result"},  result,      e.res);
          chk({e.name, ".zero"},    W'(zero),    W'(e.z));
          chk({e.name, ".illegal"}, W'(illegal), W'(e.il));
          chk({e.name, ".hi"},      hi,          e.hi);
          chk({e.name, ".lo"},      lo,          e.lo);
        end
      end
    end
  end

  // Present a request (called just after a posedge), push its expectation, release after accept
  task automatic issue(logic [2:0] op, logic [5:0] fn, logic [W-1:0] a, logic [W-1:0] b, exp_t e);
    alu_op = op; funct = fn; a_in = a; b_in = b; valid_in = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk({name, ".timeout"}, W'(q.size()), W'(0));
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic mul_op(string name, logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] pr;
    pr = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    m_hi = pr[2*W-1:W]; m_lo = pr[W-1:0];
    issue(3'b010, 6'b011001, a, b, mk(name, m_lo, 1'b0));
    wait_idle(name);
  endtask

  task automatic div_op(string name, logic [W-1:0] a, logic [W-1:0] b);
`ifdef ALU_DIV_EN
    if (b == '0) begin m_lo = '1; m_hi = a; end
    else begin m_lo = a / b; m_hi = a % b; end
    issue(3'b010, 6'b011011, a, b, mk(name, m_lo, 1'b0));
`else
    issue(3'b010, 6'b011011, a, b, mk(name, '0, 1'b1));
    @(negedge clk);
    chk({name, ".latency1"}, W'(valid_out), W'(1));
    @(posedge clk); #1;
`endif
    wait_idle(name);
  endtask

  vec_t vt[$];
  int   vcount;

  initial begin
    vt = '{
      '{"mfhi_reset", 3'b010, 6'b010000, 32'd9,        32'd9,        32'd0,          1'b0},
      '{"sub_5_7",    3'b010, 6'b100010, 32'd5,        32'd7,        32'hFFFF_FFFE,  1'b0},
      '{"slt_5_7",    3'b010, 6'b101010, 32'd5,        32'd7,        32'd1,          1'b0},
      '{"slt_m1_1",   3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1,       32'd1,          1'b0},
      '{"slt_1_m1",   3'b010, 6'b101010, 32'd1,        32'hFFFF_FFFF, 32'd0,         1'b0},
      '{"slt_7_5",    3'b010, 6'b101010, 32'd7,        32'd5,        32'd0,          1'b0},
      '{"lw_add",     3'b000, 6'b111111, 32'd3,        32'd4,        32'd7,          1'b0},
      '{"beq_sub",    3'b001, 6'b000000, 32'd9,        32'd9,        32'd0,          1'b0},
      '{"add_wrap",   3'b010, 6'b100000, 32'hFFFF_FFFF, 32'd1,       32'd0,          1'b0},
      '{"and",        3'b010, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0},
      '{"or",         3'b010, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0},
      '{"ill_op011",  3'b011, 6'b100000, 32'd1,        32'd2,        32'd0,          1'b1},
      '{"ill_f3f",    3'b010, 6'b111111, 32'd1,        32'd2,        32'd0,          1'b1},
      '{"ill_op111",  3'b111, 6'b100000, 32'd5,        32'd5,        32'd0,          1'b1}
    };

    rst = 1'b1; valid_in = 1'b0; alu_op = '0; funct = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready",     W'(ready),     W'(1));
    chk("rst.valid_out", W'(valid_out), W'(0));
    chk("rst.result",    result,        W'(0));
    chk("rst.zero",      W'(zero),      W'(0));
    chk("rst.hi",        hi,            W'(0));
    chk("rst.lo",        lo,            W'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back single-cycle vectors, one per clock
    for (int i = 0; i < vt.size(); i++)
      issue(vt[i].op, vt[i].fn, vt[i].a, vt[i].b, mk(vt[i].name, vt[i].res, vt[i].il));
    wait_idle("vectors");

    // multu with latency/ready profile and an ignored add while busy
    m_hi = 32'd1; m_lo = 32'hFFFF_FFFE;
    issue(3'b010, 6'b011001, 32'hFFFF_FFFF, 32'd2, mk("multu_ff_2", 32'hFFFF_FFFE, 1'b0));
    alu_op = 3'b000; a_in = 32'd1; b_in = 32'd1; valid_in = 1'b1;
    vcount = 0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k <= W) begin
        chk("multu.ready_low", W'(ready), W'(0));
        if (valid_out) vcount++;
        if (k == W) valid_in = 1'b0;
      end else begin
        chk("multu.ready_back", W'(ready),     W'(1));
        chk("multu.valid_at",   W'(valid_out), W'(1));
      end
    end
    chk("multu.no_early_valid", W'(vcount), W'(0));
    @(posedge clk); #1;
    issue(3'b010, 6'b010000, 32'd0, 32'd0, mk("mfhi_after_mul", 32'd1, 1'b0));
    issue(3'b010, 6'b010010, 32'd0, 32'd0, mk("mflo_after_mul", 32'hFFFF_FFFE, 1'b0));
    wait_idle("mf_after_mul");
    @(negedge clk);
    chk("ignored_add.no_valid", W'(valid_out), W'(0));
    @(posedge clk); #1;

    mul_op("multu_rand0", $urandom, $urandom);
    mul_op("multu_rand1", $urandom, 32'hFFFF_FFFF);
    mul_op("multu_zero", 32'd0, 32'h1234_5678);

    div_op("divu_100_7", 32'd100, 32'd7);
    div_op("divu_100_0", 32'd100, 32'd0);
    div_op("divu_rand", $urandom, $urandom_range(1, 1000));
    issue(3'b010, 6'b010000, 32'd0, 32'd0, mk("mfhi_after_div", m_hi, 1'b0));
    wait_idle("mfhi_after_div");

    // Reset at cycle 10 of a multiply aborts it silently
    issue(3'b010, 6'b011001, 32'd3, 32'd5, mk("aborted", 32'd15, 1'b0));
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("abort.ready",  W'(ready), W'(1));
    chk("abort.hi",     hi,        W'(0));
    chk("abort.lo",     lo,        W'(0));
    chk("abort.result", result,    W'(0));
    vcount = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (valid_out) vcount++;
    end
    chk("abort.no_valid", W'(vcount), W'(0));
    @(posedge clk); #1;
    issue(3'b010, 6'b010010, 32'd0, 32'd0, mk("mflo_after_abort", 32'd0, 1'b0));
    wait_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
